// File: rtl/alu_pkg.sv
// Shared definitions for the ALU slice: opcodes, FSM state encoding,
// default datapath width and the divider step-counter width.
package alu_pkg;

  localparam int unsigned DEFAULT_DATA_W = 12;
  localparam int unsigned OP_W           = 3;
  localparam int unsigned CNT_W          = 5;

  localparam logic [OP_W-1:0] ALU_ADD = 3'b001;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b010;
  localparam logic [OP_W-1:0] ALU_MUL = 3'b011;
  localparam logic [OP_W-1:0] ALU_DIV = 3'b100;
  localparam logic [OP_W-1:0] ALU_MOD = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    DIVIDE = 1'b1
  } alu_state_t;

  // True for the five defined opcodes (001..101).
  function automatic logic op_valid(input logic [OP_W-1:0] op);
    return (op >= ALU_ADD) && (op <= ALU_MOD);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   load            capture dividend/divisor and start DATA_W steps
//   dividend        numerator captured on load
//   divisor         denominator captured on load (caller excludes zero)
//   last_c          current step is the final one (counter == 1)
//   quotient_c      quotient after the current step
//   remainder_c     partial remainder after the current step
module alu_divider
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              last_c,
  output logic [DATA_W-1:0] quotient_c,
  output logic [DATA_W-1:0] remainder_c
);

  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [DATA_W:0]   shifted_c;
  logic [DATA_W-1:0] rem_n_c;
  logic [DATA_W-1:0] quo_n_c;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted_c = {rem_q, quo_q[DATA_W-1]};
    rem_n_c   = shifted_c[DATA_W-1:0];
    quo_n_c   = {quo_q[DATA_W-2:0], 1'b0};
    if (shifted_c >= {1'b0, dvs_q}) begin
      // Difference is below the divisor, so it always fits in DATA_W bits.
      rem_n_c = DATA_W'(shifted_c - {1'b0, dvs_q});
      quo_n_c = {quo_q[DATA_W-2:0], 1'b1};
    end
  end

  assign last_c      = (cnt_q == CNT_W'(1));
  assign quotient_c  = quo_n_c;
  assign remainder_c = rem_n_c;

  // Datapath registers; the quotient register doubles as the dividend shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CNT_W'(DATA_W);
    end else if (cnt_q != '0) begin
      rem_q <= rem_n_c;
      quo_q <= quo_n_c;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_unit.sv
// Command-driven ALU: single-cycle add/sub/mul, iterative div/mod.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   alu_start    one-cycle command strobe
//   alu_en       opcode (add/sub/mul/div/mod), other codes ignored
//   a, b         operands, captured when a command is accepted
//   result       registered accumulator
//   z            registered zero flag of result
//   busy         division in progress
//   done         one-cycle pulse when a new result becomes visible
//   dz           last accepted command divided by zero
module alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_start,
  input  logic [2:0]        alu_en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              busy,
  output logic              done,
  output logic              dz
);

  alu_state_t        state_q;
  alu_state_t        state_n;
  logic [OP_W-1:0]   op_q;
  logic [OP_W-1:0]   op_n;
  logic [DATA_W-1:0] result_n;
  logic              z_n;
  logic              dz_n;
  logic              done_n;
  logic              div_load_c;
  logic              div_last_c;
  logic [DATA_W-1:0] div_quo_c;
  logic [DATA_W-1:0] div_rem_c;

  alu_divider #(
    .DATA_W (DATA_W)
  ) u_divider (
    .clk         (clk),
    .rst         (rst),
    .load        (div_load_c),
    .dividend    (a),
    .divisor     (b),
    .last_c      (div_last_c),
    .quotient_c  (div_quo_c),
    .remainder_c (div_rem_c)
  );

  // Command FSM plus next values of the output registers.
  always_comb begin
    state_n    = state_q;
    op_n       = op_q;
    result_n   = result;
    dz_n       = dz;
    done_n     = 1'b0;
    div_load_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (alu_start && op_valid(alu_en)) begin
          case (alu_en)
            ALU_ADD: begin
              result_n = a + b;
              dz_n     = 1'b0;
              done_n   = 1'b1;
            end
            ALU_SUB: begin
              result_n = a - b;
              dz_n     = 1'b0;
              done_n   = 1'b1;
            end
            ALU_MUL: begin
              result_n = a * b;
              dz_n     = 1'b0;
              done_n   = 1'b1;
            end
            ALU_DIV, ALU_MOD: begin
              if (b == '0) begin
                // Divide-by-zero resolves immediately without iterating.
                result_n = (alu_en == ALU_DIV) ? '1 : a;
                dz_n     = 1'b1;
                done_n   = 1'b1;
              end else begin
                state_n    = DIVIDE;
                op_n       = alu_en;
                div_load_c = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      DIVIDE: begin
        if (div_last_c) begin
          state_n  = IDLE;
          result_n = (op_q == ALU_DIV) ? div_quo_c : div_rem_c;
          dz_n     = 1'b0;
          done_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Tracks result, so it only moves when result is written.
    z_n = (result_n == '0);
  end

  // State and output registers; reset wins over any command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      result  <= '0;
      z       <= 1'b1;
      dz      <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      op_q    <= op_n;
      result  <= result_n;
      z       <= z_n;
      dz      <= dz_n;
      done    <= done_n;
    end
  end

  assign busy = (state_q == DIVIDE);

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit (DATA_W=12): directed cases plus
// randomized commands against a plain-arithmetic reference model.
module tb_alu_unit;

  localparam int unsigned W = 12;

  logic         clk;
  logic         rst;
  logic         alu_start;
  logic [2:0]   alu_en;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         z;
  logic         busy;
  logic         done;
  logic         dz;

  int n_cmp;
  int n_bad;

  // Reference model state: what result/z/dz should currently hold.
  logic [W-1:0] m_res;
  logic         m_z;
  logic         m_dz;

  alu_unit #(
    .DATA_W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_start (alu_start),
    .alu_en    (alu_en),
    .a         (a),
    .b         (b),
    .result    (result),
    .z         (z),
    .busy      (busy),
    .done      (done),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".result"}, 32'(result), 32'(m_res));
    chk({tag, ".z"}, 32'(z), 32'(m_z));
    chk({tag, ".dz"}, 32'(dz), 32'(m_dz));
  endtask

  // Expected outcome of an operation from arithmetic definitions.
  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] av,
                                          input logic [W-1:0] bv);
    int unsigned x, y, r;
    x = 32'(av);
    y = 32'(bv);
    case (op)
      3'd1:    r = x + y;
      3'd2:    r = x - y;
      3'd3:    r = x * y;
      3'd4:    r = (y == 0) ? 32'hFFF : x / y;
      3'd5:    r = (y == 0) ? x : x % y;
      default: r = 0;
    endcase
    return W'(r % 4096);
  endfunction

  // Called at a negedge: issue one command, follow it to completion.
  // With poke set, alu_start is hammered with random commands while busy.
  task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit poke);
    bit valid, multi;
    valid = (op >= 3'd1) && (op <= 3'd5);
    multi = ((op == 3'd4) || (op == 3'd5)) && (bv != '0);
    alu_start = 1'b1;
    alu_en    = op;
    a         = av;
    b         = bv;
    @(negedge clk);
    alu_start = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    if (multi) begin
      for (int k = 0; k < int'(W); k++) begin
        chk("div.busy", 32'(busy), 32'd1);
        chk("div.done_early", 32'(done), 32'd0);
        chk_regs("div.hold");
        if (poke) begin
          alu_start = 1'b1;
          alu_en    = 3'($urandom_range(1, 5));
          a         = W'($urandom);
          b         = W'($urandom);
        end
        @(negedge clk);
      end
      alu_start = 1'b0;
    end
    if (valid) begin
      m_res = ref_op(op, av, bv);
      m_z   = (m_res == '0);
      m_dz  = (op >= 3'd4) && (bv == '0);
    end
    chk("cmd.done", 32'(done), valid ? 32'd1 : 32'd0);
    chk("cmd.busy", 32'(busy), 32'd0);
    chk_regs("cmd");
  endtask

  // One quiet cycle: no done pulse, registers hold.
  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk_regs(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_res = '0;
    m_z   = 1'b1;
    m_dz  = 1'b0;

    // Reset held with a competing add command: reset must win.
    rst       = 1'b1;
    alu_start = 1'b1;
    alu_en    = 3'd1;
    a         = W'(5);
    b         = W'(5);
    repeat (3) @(negedge clk);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk_regs("rst");
    rst       = 1'b0;
    alu_start = 1'b0;

    // Wrapping add, then done must drop after one cycle.
    run_cmd(3'd1, 12'hFFF, 12'h001, 1'b0);
    chk("add_wrap.res", 32'(result), 32'h000);
    idle_chk("add_wrap.after");

    run_cmd(3'd2, 12'd3, 12'd5, 1'b0);
    chk("sub_neg.res", 32'(result), 32'hFFE);
    run_cmd(3'd3, 12'h040, 12'h040, 1'b0);
    chk("mul_trunc.res", 32'(result), 32'h000);
    chk("mul_trunc.z", 32'(z), 32'd1);
    idle_chk("mul.after");

    // Division with a strobe hammered during busy; mod issued in the done cycle.
    run_cmd(3'd4, 12'd100, 12'd7, 1'b1);
    chk("div100_7.res", 32'(result), 32'd14);
    run_cmd(3'd5, 12'd100, 12'd7, 1'b0);
    chk("mod100_7.res", 32'(result), 32'd2);
    idle_chk("mod.after");

    run_cmd(3'd4, 12'd25, 12'd0, 1'b0);
    chk("div0.res", 32'(result), 32'hFFF);
    chk("div0.dz", 32'(dz), 32'd1);
    run_cmd(3'd5, 12'd25, 12'd0, 1'b0);
    chk("mod0.res", 32'(result), 32'd25);
    chk("mod0.dz", 32'(dz), 32'd1);

    // Invalid opcodes leave everything untouched.
    run_cmd(3'd6, 12'd9, 12'd9, 1'b0);
    run_cmd(3'd0, 12'd9, 12'd9, 1'b0);
    chk("inval.dz_kept", 32'(dz), 32'd1);
    idle_chk("inval.after");

    // Reset landing on the 5th divide step aborts silently.
    alu_start = 1'b1;
    alu_en    = 3'd4;
    a         = 12'd100;
    b         = 12'd7;
    @(negedge clk);
    alu_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("abort.busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    m_res = '0;
    m_z   = 1'b1;
    m_dz  = 1'b0;
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.busy_clr", 32'(busy), 32'd0);
    chk_regs("abort");
    repeat (3) idle_chk("abort.quiet");
    run_cmd(3'd1, 12'd2, 12'd2, 1'b0);
    chk("abort.add", 32'(result), 32'd4);

    // Randomized commands against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]   op;
      logic [W-1:0] av, bv;
      op = 3'($urandom_range(0, 7));
      av = W'($urandom);
      bv = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom >> $urandom_range(0, 10));
      run_cmd(op, av, bv, ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 2) == 0) idle_chk("rand.idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
